modulator: RTL and testbench

- Self-contained AM test-signal generator for the SDR transmitter datapath; no data inputs.
- Produces a single-bit output: a square carrier gated by a PWM envelope.
- The envelope duty sweeps as a triangle, so the output is an amplitude-modulated carrier.
- Used to drive the TX output stage and for bring-up and scope checks.

---
 rtl/modulator.sv | 103 ++++++++++
 tb/tb_modulator.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/modulator.sv
// AM test-signal generator: a free-running square carrier gated by a PWM
// envelope whose duty sweeps as a triangle, registered onto a single output.
module modulator #(
  parameter int FOO                  = 10,
  parameter int AM_CLKS_IN_PWM_STEPS = 16,
  parameter int AM_PWM_STEPS         = 16
) (
  input  logic clk,
  input  logic rst,
  output logic pwm
);

  localparam int PW = (AM_CLKS_IN_PWM_STEPS > 1) ? $clog2(AM_CLKS_IN_PWM_STEPS) : 1;
  localparam int SW = $clog2(AM_PWM_STEPS);
  localparam int DW = $clog2(AM_PWM_STEPS + 1);
  localparam int CW = (FOO > 1) ? $clog2(FOO) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(AM_CLKS_IN_PWM_STEPS - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(AM_PWM_STEPS - 1);
  localparam logic [DW-1:0] DUTY_MAX   = DW'(AM_PWM_STEPS);
  localparam logic [DW-1:0] DUTY_TURN  = DW'(AM_PWM_STEPS - 1);
  localparam logic [CW-1:0] CCNT_LAST  = CW'(FOO - 1);

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  logic [PW-1:0] presc;
  logic [SW-1:0] step;
  logic [DW-1:0] duty;
  dir_t          dir;
  logic [CW-1:0] ccnt;
  logic          carrier;

  logic presc_wrap;
  logic end_of_period;
  logic ccnt_wrap;
  logic env;

  assign presc_wrap    = (presc == PRESC_LAST);
  assign end_of_period = presc_wrap && (step == STEP_LAST);
  assign ccnt_wrap     = (ccnt == CCNT_LAST);
  // step is zero-extended so duty==AM_PWM_STEPS keeps env high all period.
  assign env           = (DW'(step) < duty);

  // Envelope timebase and triangle duty sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      step  <= '0;
      duty  <= '0;
      dir   <= DIR_UP;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge state.
      presc <= presc_wrap ? '0 : presc + 1'b1;

      if (presc_wrap) begin
        step <= (step == STEP_LAST) ? '0 : step + 1'b1;
      end

      if (end_of_period) begin
        if (dir == DIR_UP) begin
          if (duty == DUTY_MAX) begin
            duty <= DUTY_TURN;
            dir  <= DIR_DOWN;
          end else begin
            duty <= duty + 1'b1;
          end
        end else begin
          if (duty == '0) begin
            duty <= DW'(1);
            dir  <= DIR_UP;
          end else begin
            duty <= duty - 1'b1;
          end
        end
      end
    end
  end

  // Carrier is free-running and never realigned to PWM period boundaries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ccnt    <= '0;
      carrier <= 1'b1;
    end else begin
      ccnt <= ccnt_wrap ? '0 : ccnt + 1'b1;
      if (ccnt_wrap) begin
        carrier <= ~carrier;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= env & carrier;
    end
  end

endmodule

// File: tb/tb_modulator.sv
// Scoreboard bench for modulator: three parameterisations share clk/rst and
// are compared every clock against an arithmetic reference model.
module tb_modulator;

  logic clk;
  logic rst;
  logic pwm_s;
  logic pwm_d;
  logic pwm_c;

  int n_cmp = 0;
  int n_err = 0;

  logic run = 1'b0;
  int   cyc = 0;
  logic q_s[$];
  logic q_d[$];
  logic q_c[$];

  int k_s = 0;
  int k_d = 0;
  int k_c = 0;
  int hi_p0 = 0;
  int hi_p1 = 0;
  int early_hi = 0;

  modulator #(.FOO(2), .AM_CLKS_IN_PWM_STEPS(2), .AM_PWM_STEPS(4)) u_small (
    .clk(clk), .rst(rst), .pwm(pwm_s)
  );
  modulator #(.FOO(10), .AM_CLKS_IN_PWM_STEPS(16), .AM_PWM_STEPS(16)) u_def (
    .clk(clk), .rst(rst), .pwm(pwm_d)
  );
  modulator #(.FOO(1), .AM_CLKS_IN_PWM_STEPS(1), .AM_PWM_STEPS(2)) u_corner (
    .clk(clk), .rst(rst), .pwm(pwm_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output after t+1 edges since release: period index -> triangle
  // duty, step index vs duty for the envelope, carrier high on even FOO-blocks.
  function automatic logic model(input int t, input int foo, input int c, input int n);
    int p;
    int m;
    int duty;
    int step;
    p    = t / (n * c);
    m    = p % (2 * n);
    duty = (m <= n) ? m : 2 * n - m;
    step = (t / c) % n;
    return (step < duty) && (((t / foo) % 2) == 0);
  endfunction

  always @(posedge clk) begin
    if (!run) begin
      cyc = 0;
    end else begin
      q_s.push_back(model(cyc, 2, 2, 4));
      q_d.push_back(model(cyc, 10, 16, 16));
      q_c.push_back(model(cyc, 1, 1, 2));
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!run) begin
      k_s = 0;
      k_d = 0;
      k_c = 0;
      hi_p0 = 0;
      hi_p1 = 0;
      early_hi = 0;
    end else begin
      if (q_s.size() > 0) begin
        check("small_pwm", pwm_s, q_s.pop_front());
        k_s++;
        if (pwm_s === 1'b1) begin
          if (k_s <= 8) hi_p0++;
          else if (k_s <= 16) hi_p1++;
        end
      end
      if (q_d.size() > 0) begin
        check("default_pwm", pwm_d, q_d.pop_front());
        k_d++;
        if (k_d <= 256 && pwm_d !== 1'b0) early_hi++;
      end
      if (q_c.size() > 0) begin
        check("corner_pwm", pwm_c, q_c.pop_front());
        k_c++;
      end
    end
  end

  initial begin
    logic found;
    rst = 1'b0;

    repeat (5) begin
      @(negedge clk);
      check("rst_small", pwm_s, 1'b0);
      check("rst_default", pwm_d, 1'b0);
      check("rst_corner", pwm_c, 1'b0);
    end

    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    repeat (9000) @(negedge clk);

    check_int("small_period0_high", hi_p0, 0);
    check_int("small_period1_high", hi_p1, 2);
    check_int("default_first256_high", early_hi, 0);

    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (pwm_d === 1'b1) found = 1'b1;
    end
    check("async_wait_pulse", found, 1'b1);

    #1;
    rst = 1'b0;
    run = 1'b0;
    #1;
    check("async_small", pwm_s, 1'b0);
    check("async_default", pwm_d, 1'b0);
    check("async_corner", pwm_c, 1'b0);
    q_s.delete();
    q_d.delete();
    q_c.delete();

    repeat (4) begin
      @(negedge clk);
      check("hold_small", pwm_s, 1'b0);
      check("hold_default", pwm_d, 1'b0);
      check("hold_corner", pwm_c, 1'b0);
    end

    rst = 1'b1;
    run = 1'b1;
    repeat (600) @(negedge clk);

    check_int("restart_period0_high", hi_p0, 0);
    check_int("restart_period1_high", hi_p1, 2);
    check_int("restart_default_first256_high", early_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
